// File: rtl/bip_run_controller.sv
// Run/report sequencer for the BIP CPU: start on an rx command, run the core until HLT,
// then send the ACC snapshot and cycle count over the UART. Optional watchdog: RUN_TIMEOUT_EN.
module bip_run_controller #(
   parameter int unsigned ACC_W      = 16,
   parameter int unsigned CNT_W      = 32,
   parameter logic [7:0]  START_CMD  = 8'h53,
   parameter int unsigned MAX_CYCLES = 1000000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             rx_done,
   input  logic [7:0]       rx_data,
   input  logic [4:0]       opcode,
   input  logic [ACC_W-1:0] acc,
   input  logic             tx_done,
   output logic             tx_start,
   output logic [7:0]       tx_data,
   output logic             cpu_rst,
   output logic             cpu_en,
   output logic             busy
);

   localparam int unsigned NB    = ACC_W / 8 + CNT_W / 8;
   localparam int unsigned IDX_W = $clog2(NB + 2);
   localparam logic [4:0]  OP_HLT = 5'b00000;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_CLR  = 3'd1;
   localparam logic [2:0] S_RUN  = 3'd2;
   localparam logic [2:0] S_LOAD = 3'd3;
   localparam logic [2:0] S_WAIT = 3'd4;

`ifdef RUN_TIMEOUT_EN
   localparam logic WDOG_EN = 1'b1;
`else
   localparam logic WDOG_EN = 1'b0;
`endif
   localparam logic [CNT_W-1:0] WDOG_LIMIT = CNT_W'(MAX_CYCLES - 1);

   logic [2:0]             state_q, state_d;
   logic [CNT_W-1:0]       count_q, count_d;
   logic [ACC_W-1:0]       snap_q, snap_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic                   hdr_q, hdr_d;
   logic                   tx_start_q, tx_start_d;
   logic [7:0]             tx_data_q, tx_data_d;
   logic                   cpu_rst_q, cpu_rst_d;
   logic                   cpu_en_q, cpu_en_d;
   logic                   busy_q, busy_d;

   logic                   wdog_hit;
   logic [CNT_W+ACC_W-1:0] frame_w;
   logic [IDX_W-1:0]       sel_w;
   logic [IDX_W-1:0]       last_idx;
   logic [7:0]             byte_w;

   assign wdog_hit = WDOG_EN && (count_q == WDOG_LIMIT);

   // With a timeout header, frame byte k sits at index k+1.
   always_comb begin
      frame_w  = {count_q, snap_q};
      sel_w    = hdr_q ? (idx_q - IDX_W'(1)) : idx_q;
      last_idx = hdr_q ? IDX_W'(NB) : IDX_W'(NB - 1);
      byte_w   = '0;
      if (hdr_q && (idx_q == '0)) begin
         byte_w = 8'hEE;
      end else begin
         for (int unsigned i = 0; i < NB; i++) begin
            if (sel_w == IDX_W'(i)) byte_w = frame_w[8*i +: 8];
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      snap_d     = snap_q;
      idx_d      = idx_q;
      hdr_d      = hdr_q;
      tx_data_d  = tx_data_q;
      tx_start_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (rx_done && (rx_data == START_CMD)) state_d = S_CLR;
         end
         S_CLR: begin
            count_d = '0;
            hdr_d   = 1'b0;
            state_d = S_RUN;
         end
         S_RUN: begin
            if ((opcode == OP_HLT) || wdog_hit) begin
               snap_d  = acc;
               idx_d   = '0;
               hdr_d   = (opcode != OP_HLT);
               state_d = S_LOAD;
            end else if (count_q != '1) begin
               count_d = count_q + CNT_W'(1);
            end
         end
         S_LOAD: begin
            tx_data_d  = byte_w;
            tx_start_d = 1'b1;
            state_d    = S_WAIT;
         end
         S_WAIT: begin
            if (tx_done) begin
               if (idx_q == last_idx) begin
                  state_d = S_IDLE;
               end else begin
                  idx_d   = idx_q + IDX_W'(1);
                  state_d = S_LOAD;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
      // Level outputs are registered from the next state so they align with it.
      cpu_rst_d = (state_d == S_CLR);
      cpu_en_d  = (state_d == S_RUN);
      busy_d    = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         count_q    <= '0;
         snap_q     <= '0;
         idx_q      <= '0;
         hdr_q      <= 1'b0;
         tx_start_q <= 1'b0;
         tx_data_q  <= '0;
         cpu_rst_q  <= 1'b0;
         cpu_en_q   <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         snap_q     <= snap_d;
         idx_q      <= idx_d;
         hdr_q      <= hdr_d;
         tx_start_q <= tx_start_d;
         tx_data_q  <= tx_data_d;
         cpu_rst_q  <= cpu_rst_d;
         cpu_en_q   <= cpu_en_d;
         busy_q     <= busy_d;
      end
   end

   assign tx_start = tx_start_q;
   assign tx_data  = tx_data_q;
   assign cpu_rst  = cpu_rst_q;
   assign cpu_en   = cpu_en_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_bip_run_controller.sv
// Directed bench for bip_run_controller: start handshake, HLT frames, mid-frame reset,
// ignored strobes and (with RUN_TIMEOUT_EN) the watchdog header frame.
module tb_bip_run_controller;

   localparam logic [7:0] START = 8'h53;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        rx_done;
   logic [7:0]  rx_data;
   logic [4:0]  opcode;
   logic [15:0] acc;
   logic        tx_done;
   logic        tx_start;
   logic [7:0]  tx_data;
   logic        cpu_rst;
   logic        cpu_en;
   logic        busy;

   int          n_cmp = 0;
   int          n_mis = 0;
   logic [7:0]  exp_b [8];
   int          n_exp;

   bip_run_controller #(
      .ACC_W      (16),
      .CNT_W      (32),
      .START_CMD  (START),
      .MAX_CYCLES (8)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .rx_done  (rx_done),
      .rx_data  (rx_data),
      .opcode   (opcode),
      .acc      (acc),
      .tx_done  (tx_done),
      .tx_start (tx_start),
      .tx_data  (tx_data),
      .cpu_rst  (cpu_rst),
      .cpu_en   (cpu_en),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected frame: optional EE header, ACC LSB first, then 32-bit count LSB first.
   task automatic build_exp(input logic [15:0] a, input logic [31:0] c, input logic hdr);
      int p;
      p = 0;
      if (hdr) begin
         exp_b[0] = 8'hEE;
         p = 1;
      end
      exp_b[p]   = a[7:0];
      exp_b[p+1] = a[15:8];
      exp_b[p+2] = c[7:0];
      exp_b[p+3] = c[15:8];
      exp_b[p+4] = c[23:16];
      exp_b[p+5] = c[31:24];
      n_exp = p + 6;
   endtask

   task automatic send_rx(input logic [7:0] b);
      rx_data = b;
      rx_done = 1'b1;
      tick();
      rx_done = 1'b0;
   endtask

   // Starts a run, feeds nops non-HLT opcodes, then HLT; acc is changed after the halt.
   task automatic do_run(input logic [15:0] a, input int nops, input logic spur_txd);
      acc    = a;
      opcode = 5'd7;
      send_rx(START);
      chk("cpu_rst_on", cpu_rst, 1);
      chk("busy_on", busy, 1);
      tick();
      chk("cpu_rst_off", cpu_rst, 0);
      chk("cpu_en_on", cpu_en, 1);
      for (int i = 0; i < nops; i++) begin
         opcode  = 5'((i % 30) + 1);
         tx_done = spur_txd && (i == 1);
         tick();
         tx_done = 1'b0;
      end
      opcode = 5'b00000;
      tick();
      chk("cpu_en_off", cpu_en, 0);
      acc = ~a;
   endtask

   // Receives n_exp bytes, answering tx_done 10 cycles after each tx_start.
   task automatic get_frame(input int abort_at, input int rx_at, input logic collide);
      int k;
      for (int i = 0; i < n_exp; i++) begin
         k = 0;
         while (tx_start !== 1'b1 && k < 40) begin
            tick();
            k++;
         end
         chk("tx_start_seen", tx_start, 1);
         if (tx_start !== 1'b1) return;
         chk($sformatf("byte%0d", i), tx_data, exp_b[i]);
         if (i == abort_at) begin
            repeat (3) tick();
            rst_n = 1'b0;
            #1;
            chk("rst_busy", busy, 0);
            chk("rst_cpu_en", cpu_en, 0);
            chk("rst_cpu_rst", cpu_rst, 0);
            chk("rst_tx_start", tx_start, 0);
            chk("rst_tx_data", tx_data, 0);
            tick();
            rst_n = 1'b1;
            return;
         end
         for (int c = 0; c < 10; c++) begin
            tick();
            if (c == 0) chk("tx_start_pulse", tx_start, 0);
            if (c == 4 && i == rx_at) begin
               rx_data = START;
               rx_done = 1'b1;
            end
            if (c == 5) rx_done = 1'b0;
            if (c == 7 && i == rx_at) chk("rx_in_wait_cpu_rst", cpu_rst, 0);
         end
         chk($sformatf("byte%0d_hold", i), tx_data, exp_b[i]);
         tx_done = 1'b1;
         if (collide && i == n_exp - 1) begin
            rx_data = START;
            rx_done = 1'b1;
         end
         tick();
         tx_done = 1'b0;
         rx_done = 1'b0;
      end
      chk("busy_end", busy, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      int k;
      rst_n   = 1'b0;
      rx_done = 1'b0;
      rx_data = 8'h00;
      opcode  = 5'd0;
      acc     = 16'h0000;
      tx_done = 1'b0;
      #1;
      chk("reset_busy", busy, 0);
      chk("reset_cpu_en", cpu_en, 0);
      chk("reset_cpu_rst", cpu_rst, 0);
      chk("reset_tx_start", tx_start, 0);
      chk("reset_tx_data", tx_data, 0);
      repeat (3) tick();
      rst_n = 1'b1;
      tick();

      // Non-start byte is ignored.
      send_rx(8'h41);
      chk("ign_cpu_rst", cpu_rst, 0);
      chk("ign_busy", busy, 0);
      tick();
      chk("ign_busy2", busy, 0);

      // Five instructions then HLT.
      do_run(16'h1234, 5, 1'b0);
      build_exp(16'h1234, 32'd5, 1'b0);
      get_frame(-1, -1, 1'b0);

      // HLT on the first RUN cycle.
      do_run(16'h0000, 0, 1'b0);
      build_exp(16'h0000, 32'd0, 1'b0);
      get_frame(-1, -1, 1'b0);

      // Reset while waiting on byte 3, then a fresh full run.
      do_run(16'hA5C3, 5, 1'b0);
      build_exp(16'hA5C3, 32'd5, 1'b0);
      get_frame(3, -1, 1'b0);
      repeat (2) tick();
      chk("post_abort_busy", busy, 0);
      chk("post_abort_tx_start", tx_start, 0);
      do_run(16'h00FF, 3, 1'b0);
      build_exp(16'h00FF, 32'd3, 1'b0);
      get_frame(-1, -1, 1'b0);

      // Spurious tx_done in RUN, start byte in WAIT, start byte colliding with final tx_done.
      do_run(16'h0BAD, 4, 1'b1);
      build_exp(16'h0BAD, 32'd4, 1'b0);
      get_frame(-1, 2, 1'b1);
      repeat (2) tick();
      chk("collide_cpu_rst", cpu_rst, 0);
      chk("collide_busy", busy, 0);

      // Run with no HLT: watchdog stops it only when enabled.
      acc    = 16'h7E81;
      opcode = 5'd1;
      send_rx(START);
      tick();
      chk("wd_cpu_en_on", cpu_en, 1);
      k = 0;
      while (cpu_en === 1'b1 && k < 20) begin
         tick();
         k++;
      end
`ifdef RUN_TIMEOUT_EN
      chk("wd_run_cycles", k, 8);
      build_exp(16'h7E81, 32'd7, 1'b1);
      get_frame(-1, -1, 1'b0);
`else
      chk("no_wd_cpu_en", cpu_en, 1);
      chk("no_wd_cycles", k, 20);
      opcode = 5'b00000;
      tick();
      build_exp(16'h7E81, 32'd20, 1'b0);
      get_frame(-1, -1, 1'b0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
